wt_dcache_rd_ctrl: RTL and testbench

//  Read controller for one load-side port (load unit or PTW) of the write-through L1 dcache.
//  - Accepts core read requests and arbitrates for the cache-memory read port.
//  - Performs the tag check and returns hit data.
//  - On a miss or a non-cacheable access, issues a request to the miss unit, waits for the refill or
//    non-cacheable return, and then responds. Kills and memory-port collisions are handled too.
//  - Several instances sit between the core request ports and the shared dcache memory/miss unit.

---
 rtl/wt_dcache_rd_pkg.sv | 31 +++
 rtl/wt_dcache_rd_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_wt_dcache_rd_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_rd_pkg.sv
// Shared widths, FSM state type and the cacheable-region helper for the dcache read controller.
package wt_dcache_rd_pkg;

  localparam int unsigned PLEN  = 56;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned TAG_W = PLEN - 12;

  localparam logic [ID_W-1:0] RD_TX_ID    = 2'd1;
  localparam logic [PLEN-1:0] CACHED_BASE = 56'h0000_0000_8000_0000;
  localparam logic [PLEN-1:0] CACHED_SIZE = 56'h0000_0000_4000_0000;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    READ          = 3'd1,
    MISS_REQ      = 3'd2,
    MISS_WAIT     = 3'd3,
    KILL_MISS     = 3'd4,
    KILL_MISS_ACK = 3'd5,
    REPLAY_REQ    = 3'd6,
    REPLAY_READ   = 3'd7
  } rd_state_e;

  function automatic logic is_cacheable(input logic [PLEN-1:0] paddr);
    return (paddr >= CACHED_BASE) && (paddr < (CACHED_BASE + CACHED_SIZE));
  endfunction

endpackage

// File: rtl/wt_dcache_rd_ctrl.sv
// Read controller for one load-side port of the write-through L1 dcache.
// Define WT_DCACHE_RD_CTRL_ASSERT_EN to compile in the SVA protocol checks.
module wt_dcache_rd_ctrl
  import wt_dcache_rd_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cache_en_i,
  input  logic                   stall_i,
  output logic                   busy_o,
  input  logic                   data_req_i,
  input  logic [IDX_W+OFF_W-1:0] addr_index_i,
  input  logic [1:0]             data_size_i,
  output logic                   data_gnt_o,
  input  logic [TAG_W-1:0]       addr_tag_i,
  input  logic                   tag_valid_i,
  input  logic                   kill_req_i,
  output logic                   data_rvalid_o,
  output logic [XLEN-1:0]        data_rdata_o,
  output logic                   miss_req_o,
  input  logic                   miss_ack_i,
  input  logic                   miss_replay_i,
  input  logic                   miss_rtrn_vld_i,
  output logic                   miss_nc_o,
  output logic [2:0]             miss_size_o,
  output logic [PLEN-1:0]        miss_paddr_o,
  output logic [WAYS-1:0]        miss_vld_bits_o,
  output logic [ID_W-1:0]        miss_id_o,
  output logic                   rd_req_o,
  input  logic                   rd_ack_i,
  output logic                   rd_tag_only_o,
  output logic [IDX_W-1:0]       rd_idx_o,
  output logic [OFF_W-1:0]       rd_off_o,
  output logic [TAG_W-1:0]       rd_tag_o,
  input  logic [XLEN-1:0]        rd_data_i,
  input  logic [WAYS-1:0]        rd_vld_bits_i,
  input  logic [WAYS-1:0]        rd_hit_oh_i,
  input  logic                   wr_cl_vld_i
);

  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [1:0]       size_q, size_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WAYS-1:0]  vld_q, vld_d;
  logic             rd_ack_q;

  logic             req_new;
  logic             new_sel;
  logic             tag_chk;
  logic [TAG_W-1:0] chk_tag;
  logic             chk_nc;
  logic             chk_hit;

  assign req_new = data_req_i & ~stall_i;

  // In READ the tag arrives live from the core; after a replay it comes from the register.
  assign chk_tag = (state_q == READ) ? addr_tag_i : tag_q;
  assign chk_nc  = ~cache_en_i | ~is_cacheable({chk_tag, idx_q, off_q});
  assign chk_hit = (|rd_hit_oh_i) & ~chk_nc;

  always_comb begin
    state_d       = state_q;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    rd_req_o      = 1'b0;
    miss_req_o    = 1'b0;
    tag_chk       = 1'b0;
    new_sel       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_new) begin
          rd_req_o = 1'b1;
          new_sel  = 1'b1;
          if (rd_ack_i) begin
            data_gnt_o = 1'b1;
            state_d    = READ;
          end
        end
      end

      READ, REPLAY_READ: begin
        rd_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (tag_valid_i || (state_q == REPLAY_READ)) begin
          tag_chk = 1'b1;
          // Read data is only trustworthy if last cycle's read was granted and no refill muxed in.
          if (wr_cl_vld_i || !rd_ack_q) begin
            state_d = REPLAY_REQ;
          end else if (chk_hit) begin
            data_rvalid_o = 1'b1;
            state_d       = IDLE;
            if (req_new && (state_q == READ)) begin
              new_sel = 1'b1;
              if (rd_ack_i) begin
                data_gnt_o = 1'b1;
                state_d    = READ;
              end
            end
          end else begin
            state_d = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = KILL_MISS;
        end
      end

      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_req_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end

      KILL_MISS_ACK: begin
        miss_req_o = 1'b1;
        if (miss_replay_i) begin
          state_d = IDLE;
        end else if (miss_ack_i) begin
          state_d = KILL_MISS;
        end
      end

      KILL_MISS: begin
        if (miss_rtrn_vld_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign idx_d  = data_gnt_o ? addr_index_i[IDX_W+OFF_W-1:OFF_W] : idx_q;
  assign off_d  = data_gnt_o ? addr_index_i[OFF_W-1:0] : off_q;
  assign size_d = data_gnt_o ? data_size_i : size_q;
  assign tag_d  = ((state_q == READ) && tag_valid_i) ? addr_tag_i : tag_q;
  assign vld_d  = tag_chk ? rd_vld_bits_i : vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      tag_q    <= '0;
      vld_q    <= '0;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      tag_q    <= tag_d;
      vld_q    <= vld_d;
      rd_ack_q <= rd_ack_i;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign data_rdata_o  = rd_data_i;

  assign rd_tag_only_o = 1'b0;
  assign rd_idx_o      = new_sel ? addr_index_i[IDX_W+OFF_W-1:OFF_W] : idx_q;
  assign rd_off_o      = new_sel ? addr_index_i[OFF_W-1:0] : off_q;
  assign rd_tag_o      = (state_q == READ) ? addr_tag_i : tag_q;

  assign miss_paddr_o    = {tag_q, idx_q, off_q};
  assign miss_nc_o       = ~cache_en_i | ~is_cacheable(miss_paddr_o);
  assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
  assign miss_vld_bits_o = vld_q;
  assign miss_id_o       = RD_TX_ID;

`ifdef WT_DCACHE_RD_CTRL_ASSERT_EN
  a_hit_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rd_hit_oh_i));

  a_gnt_state: assert property (@(posedge clk_i) disable iff (rst_i)
    data_gnt_o |-> ((state_q == IDLE) || (state_q == READ)));

  a_no_rvalid_kill_miss: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == KILL_MISS) |-> !data_rvalid_o);

  a_miss_handshake: assert property (@(posedge clk_i) disable iff (rst_i)
    !(miss_req_o && miss_replay_i && miss_ack_i));
`endif

endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// Scoreboard bench for wt_dcache_rd_ctrl: randomized core/memory/miss-unit environment with a transaction-level reference.
module tb_wt_dcache_rd_ctrl;
  import wt_dcache_rd_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cache_en_i, stall_i, busy_o;
  logic             data_req_i;
  logic [11:0]      addr_index_i;
  logic [1:0]       data_size_i;
  logic             data_gnt_o;
  logic [TAG_W-1:0] addr_tag_i;
  logic             tag_valid_i, kill_req_i, data_rvalid_o;
  logic [XLEN-1:0]  data_rdata_o;
  logic             miss_req_o, miss_ack_i, miss_replay_i, miss_rtrn_vld_i, miss_nc_o;
  logic [2:0]       miss_size_o;
  logic [PLEN-1:0]  miss_paddr_o;
  logic [WAYS-1:0]  miss_vld_bits_o;
  logic [ID_W-1:0]  miss_id_o;
  logic             rd_req_o, rd_ack_i, rd_tag_only_o;
  logic [IDX_W-1:0] rd_idx_o;
  logic [OFF_W-1:0] rd_off_o;
  logic [TAG_W-1:0] rd_tag_o;
  logic [XLEN-1:0]  rd_data_i;
  logic [WAYS-1:0]  rd_vld_bits_i, rd_hit_oh_i;
  logic             wr_cl_vld_i;

  always #5 clk_i = ~clk_i;

  wt_dcache_rd_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cache_en_i(cache_en_i), .stall_i(stall_i), .busy_o(busy_o),
    .data_req_i(data_req_i), .addr_index_i(addr_index_i), .data_size_i(data_size_i),
    .data_gnt_o(data_gnt_o), .addr_tag_i(addr_tag_i), .tag_valid_i(tag_valid_i),
    .kill_req_i(kill_req_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
    .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_nc_o(miss_nc_o), .miss_size_o(miss_size_o),
    .miss_paddr_o(miss_paddr_o), .miss_vld_bits_o(miss_vld_bits_o), .miss_id_o(miss_id_o),
    .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_tag_only_o(rd_tag_only_o),
    .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o), .rd_tag_o(rd_tag_o), .rd_data_i(rd_data_i),
    .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i), .wr_cl_vld_i(wr_cl_vld_i)
  );

  typedef struct {
    logic        chk_data;
    logic [63:0] data;
  } rsp_t;

  typedef struct {
    logic        nc;
    logic [2:0]  size;
    logic [55:0] paddr;
    logic [3:0]  vld;
  } miss_t;

  rsp_t  rsp_q[$];
  miss_t miss_q[$];
  int    n_pass = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ref_cacheable(input logic [63:0] pa);
    return (pa >= 64'h8000_0000) && (pa < 64'hC000_0000);
  endfunction

  task automatic idle_inputs();
    data_req_i = 0; stall_i = 0; tag_valid_i = 0; kill_req_i = 0; wr_cl_vld_i = 0;
    miss_ack_i = 0; miss_replay_i = 0; miss_rtrn_vld_i = 0; rd_ack_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cache_en_i = 1; addr_index_i = '0; data_size_i = '0; addr_tag_i = '0;
    rd_data_i = '0; rd_vld_bits_i = '0; rd_hit_oh_i = '0;
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    rsp_q.delete();
    miss_q.delete();
    rst_i = 0;
  endtask

  // Monitor: pops an expectation whenever the DUT responds or hands a miss to the miss unit.
  initial begin
    rsp_t  e;
    miss_t m;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i === 1'b0) begin
        if (data_rvalid_o) begin
          chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            if (e.chk_data) chk("rdata", data_rdata_o, e.data);
          end
        end
        if (miss_req_o && miss_ack_i) begin
          chk("miss_expected", 64'(miss_q.size() != 0), 64'd1);
          if (miss_q.size() != 0) begin
            m = miss_q.pop_front();
            chk("miss_nc", 64'(miss_nc_o), 64'(m.nc));
            chk("miss_size", 64'(miss_size_o), 64'(m.size));
            chk("miss_paddr", 64'(miss_paddr_o), 64'(m.paddr));
            chk("miss_vld_bits", 64'(miss_vld_bits_o), 64'(m.vld));
            chk("miss_id", 64'(miss_id_o), 64'd1);
          end
        end
      end
    end
  end

  // kmode: 0 none, 1 kill at tag, 2 kill while refill pending, 3 kill at miss request, 4 kill with refill
  task automatic run_txn(input logic [11:0] idx, input logic [43:0] tag, input logic [1:0] sz,
                         input logic cen, input logic hit, input logic coll,
                         input int kmode_in, input logic rep);
    logic [63:0] pa, hdata, mdata;
    logic        nc, rhit, granted, tag_pend, outst, killed, rep_pend, rsp_seen, busy_s, mreq_s;
    logic [3:0]  oh, vb;
    int          kmode, tdly, rdly, tag_cnt, cnt, cyc;
    rsp_t        r;
    miss_t       m;

    kmode = kmode_in;
    pa    = {8'h0, tag, idx};
    nc    = !cen || !ref_cacheable(pa);
    rhit  = hit && !nc;
    if (rhit && kmode > 1) kmode = 0;
    hdata = {$urandom, $urandom};
    mdata = {$urandom, $urandom};
    oh    = hit ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
    vb    = 4'($urandom);
    tdly  = $urandom_range(0, 2);
    rdly  = (kmode == 2) ? $urandom_range(1, 4) : $urandom_range(0, 4);

    r.chk_data = (kmode == 0);
    r.data     = rhit ? hdata : mdata;
    rsp_q.push_back(r);
    if (!rhit && kmode != 1) begin
      m.nc    = nc;
      m.size  = nc ? {1'b0, sz} : 3'b111;
      m.paddr = pa[55:0];
      m.vld   = vb;
      miss_q.push_back(m);
    end

    cache_en_i = cen; rd_hit_oh_i = oh; rd_vld_bits_i = vb; data_size_i = sz;
    addr_index_i = idx; addr_tag_i = tag;
    granted = 0; tag_pend = 0; outst = 0; killed = 0; rep_pend = rep; rsp_seen = 0;
    tag_cnt = tdly; cnt = 0;

    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk_i);
      busy_s = busy_o;
      mreq_s = miss_req_o;
      if (rsp_seen && !busy_s && !outst) break;
      data_req_i = !granted; stall_i = 0; tag_valid_i = 0; wr_cl_vld_i = 0; kill_req_i = 0;
      miss_ack_i = 0; miss_replay_i = 0; miss_rtrn_vld_i = 0; rd_data_i = hdata;
      rd_ack_i = ($urandom % 4 != 0);
      if (tag_pend) begin
        if (tag_cnt == 0) begin
          tag_valid_i = 1; wr_cl_vld_i = coll; tag_pend = 0;
          if (kmode == 1) kill_req_i = 1;
        end else tag_cnt--;
      end
      if (outst) begin
        if (killed) chk("busy_after_kill", 64'(busy_s), 64'd1);
        if (cnt == 0) begin
          miss_rtrn_vld_i = 1; rd_data_i = mdata; outst = 0;
          if (kmode == 4) kill_req_i = 1;
        end else begin
          if (kmode == 2 && !killed) begin kill_req_i = 1; killed = 1; end
          cnt--;
        end
      end else if (mreq_s) begin
        if (rep_pend) begin
          miss_replay_i = 1; rep_pend = 0;
        end else begin
          if (kmode == 3 && !killed) begin
            kill_req_i = 1; killed = 1; miss_ack_i = 1'($urandom % 2);
          end else miss_ack_i = ($urandom % 3 != 0);
          if (miss_ack_i) begin outst = 1; cnt = rdly; end
        end
      end
      #2;
      if (data_gnt_o) begin
        chk("rd_idx_at_gnt", 64'(rd_idx_o), 64'(idx[11:4]));
        granted = 1; tag_pend = 1;
      end
      if (data_rvalid_o) rsp_seen = 1;
    end
    chk("txn_complete", 64'(rsp_seen && !busy_o && !outst), 64'd1);
    idle_inputs();
    if (!(rsp_seen && !busy_o && !outst)) do_reset();
  endtask

  function automatic logic [43:0] rand_tag();
    logic [43:0] t;
    case ($urandom % 6)
      0, 1, 2: t = 44'h80000 + 44'($urandom % 32'h40000);
      3: case ($urandom % 4)
           0: t = 44'h7FFFF;
           1: t = 44'h80000;
           2: t = 44'hBFFFF;
           default: t = 44'hC0000;
         endcase
      4: t = {12'($urandom), $urandom};
      default: t = 44'($urandom % 32'h10000);
    endcase
    return t;
  endfunction

  initial begin
    logic [63:0] da, db;
    int k;
    do_reset();
    rst_i = 1;
    @(negedge clk_i); #2;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_rvalid", 64'(data_rvalid_o), 64'd0);
    chk("reset_miss_req", 64'(miss_req_o), 64'd0);
    chk("reset_rd_req", 64'(rd_req_o), 64'd0);
    chk("reset_gnt", 64'(data_gnt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);

    // Directed scenarios
    run_txn(12'h040, 44'h80001, 2'd3, 1, 1, 0, 0, 0);  // hit
    run_txn(12'h080, 44'h80002, 2'd3, 1, 0, 0, 0, 0);  // cacheable miss
    run_txn(12'h100, 44'h80003, 2'd2, 0, 1, 0, 0, 0);  // nc (cache disabled)
    run_txn(12'h0C0, 44'h00001, 2'd1, 1, 1, 0, 0, 0);  // nc region even with hit vector
    run_txn(12'h140, 44'h80004, 2'd3, 1, 1, 1, 0, 0);  // collision then hit
    run_txn(12'h180, 44'h80005, 2'd3, 1, 0, 0, 2, 0);  // kill in MISS_WAIT
    run_txn(12'h1C0, 44'h80006, 2'd3, 1, 0, 0, 0, 1);  // miss replay
    run_txn(12'h200, 44'h80007, 2'd3, 1, 0, 0, 1, 0);  // kill at tag
    run_txn(12'h240, 44'hBFFFF, 2'd3, 1, 0, 0, 3, 0);  // kill at miss request
    run_txn(12'h280, 44'hC0000, 2'd0, 1, 0, 0, 4, 0);  // kill with refill

    // Stall blocks grant
    data_req_i = 1; stall_i = 1; rd_ack_i = 1; addr_index_i = 12'h3F0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #2;
      chk("stall_no_gnt", 64'(data_gnt_o), 64'd0);
      chk("stall_no_rd_req", 64'(rd_req_o), 64'd0);
    end
    idle_inputs();
    @(negedge clk_i);
    chk("stall_idle", 64'(busy_o), 64'd0);

    // Kill in IDLE is ignored
    kill_req_i = 1;
    @(negedge clk_i);
    kill_req_i = 0;
    @(negedge clk_i);
    chk("kill_idle_busy", 64'(busy_o), 64'd0);

    // Back-to-back hits
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    rsp_q.push_back('{chk_data: 1'b1, data: da});
    rsp_q.push_back('{chk_data: 1'b1, data: db});
    cache_en_i = 1; rd_hit_oh_i = 4'b0100; rd_vld_bits_i = 4'hF; data_size_i = 2'd3;
    data_req_i = 1; addr_index_i = 12'h230; rd_ack_i = 1;
    #2;
    chk("b2b_gnt_first", 64'(data_gnt_o), 64'd1);
    @(negedge clk_i);
    tag_valid_i = 1; addr_tag_i = 44'h90000; rd_data_i = da;
    data_req_i = 1; addr_index_i = 12'h5A8; rd_ack_i = 1;
    #2;
    chk("b2b_gnt_second", 64'(data_gnt_o), 64'd1);
    chk("b2b_rd_idx", 64'(rd_idx_o), 64'h5A);
    @(negedge clk_i);
    data_req_i = 0; tag_valid_i = 1; addr_tag_i = 44'hA0000; rd_data_i = db;
    @(negedge clk_i);
    idle_inputs();
    @(negedge clk_i);
    chk("b2b_idle", 64'(busy_o), 64'd0);

    // Randomized transactions
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      run_txn(12'($urandom), rand_tag(), 2'($urandom), ($urandom % 5 != 0),
              ($urandom % 2 == 0), ($urandom % 5 == 0), (k < 5) ? 0 : k - 5,
              ($urandom % 5 == 0));
    end

    repeat (4) @(negedge clk_i);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("miss_queue_empty", 64'(miss_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
